// File: rtl/memoria_datos_param.sv
`default_nettype none
// ============================================================================
//  Module      : memoria_datos_param
//  Description : Parametrised MEM-stage data RAM with byte/half/word access,
//                sign/zero extension, misalignment detection, an independent
//                debug read port and a post-reset clear sequence.
//                All state updates on the falling edge of clk so the MEM stage
//                sees load data inside its own cycle.
//  Ports       : clk, reset (async, active-high)
//                read/write/size/unsigned_ld/direccion/din -> access request
//                direccion_dbg                            -> debug word index
//                dout, dout_valid, misaligned             -> access result
//                dout_dbg                                 -> debug word
//                busy                                     -> clear in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module memoria_datos_param #(
    parameter int          DEPTH          = 1024,
    parameter int          ADDR_W         = 12,
    parameter logic [31:0] INIT_VALUE     = 32'h000001FF,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] direccion,
    input  logic [31:0]       din,
    input  logic [ADDR_W-3:0] direccion_dbg,
    output logic [31:0]       dout,
    output logic [31:0]       dout_dbg,
    output logic              dout_valid,
    output logic              misaligned,
    output logic              busy
);

    localparam int                 c_IDX_W = ADDR_W - 2;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]        r_mem [DEPTH];
    logic [c_IDX_W-1:0] r_ptr;
    logic [31:0]        r_dout;
    logic [31:0]        r_dout_dbg;
    logic               r_dout_valid;
    logic               r_misaligned;

    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_lane;
    logic               w_is_byte;
    logic               w_is_half;
    logic               w_aligned;
    logic               w_ready;
    logic               w_misaligned;
    logic               w_do_load;
    logic               w_do_store;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;

    assign w_idx     = direccion[ADDR_W-1:2];
    assign w_lane    = direccion[1:0];
    assign w_is_byte = (size == 2'b00);
    assign w_is_half = (size == 2'b01);
    // size 11 falls through to the word rules
    assign w_aligned = w_is_byte
                     | (w_is_half & ~direccion[0])
                     | (~w_is_byte & ~w_is_half & (w_lane == 2'b00));

    assign w_ready      = (r_state == ST_READY);
    assign w_misaligned = w_ready & (read | write) & ~w_aligned;
    assign w_do_load    = w_ready & read  & w_aligned;
    assign w_do_store   = w_ready & write & w_aligned;

    // Lane extraction, little-endian
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_word[{direccion[1], 4'b0000} +: 16];

    always_comb begin
        w_load = w_word;
        if (w_is_byte) begin
            w_load = unsigned_ld ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_load = unsigned_ld ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
        end
    end

    // Store data is replicated across lanes; the byte enables pick the target
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = din;
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{din[7:0]}};
        end else if (w_is_half) begin
            w_be    = direccion[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{din[15:0]}};
        end
    end

    // RAM array: clear writes whole words, stores write enabled bytes only
    always_ff @(negedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= INIT_VALUE;
        end else if (w_do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // State register
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave CLEAR on the edge that writes the last word
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_ptr == c_LAST) w_state_next = ST_READY;
            ST_READY: w_state_next = ST_READY;
            default:  w_state_next = r_state;
        endcase
    end

    // Output and pointer registers
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= '0;
            r_dout       <= '0;
            r_dout_dbg   <= '0;
            r_dout_valid <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_dout_dbg   <= r_mem[direccion_dbg];
            r_dout_valid <= w_do_load;
            r_misaligned <= w_misaligned;
            if (w_do_load) begin
                r_dout <= w_load;
            end
            if (r_state == ST_CLEAR) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_dbg   = r_dout_dbg;
    assign dout_valid = r_dout_valid;
    assign misaligned = r_misaligned;
    assign busy       = (r_state == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_memoria_datos_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memoria_datos_param
//  Description : Self-checking bench for memoria_datos_param (DEPTH=16).
//                Reference memory is kept as a little-endian byte array.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memoria_datos_param;

    localparam int          DEPTH  = 16;
    localparam int          ADDR_W = 6;
    localparam logic [31:0] INIT   = 32'h000001FF;

    logic              clk;
    logic              reset;
    logic              read;
    logic              write;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [ADDR_W-1:0] direccion;
    logic [31:0]       din;
    logic [ADDR_W-3:0] direccion_dbg;
    logic [31:0]       dout;
    logic [31:0]       dout_dbg;
    logic              dout_valid;
    logic              misaligned;
    logic              busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]  model_bytes [DEPTH*4];
    logic [31:0] model_dout;

    memoria_datos_param #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .INIT_VALUE     (INIT),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .size          (size),
        .unsigned_ld   (unsigned_ld),
        .direccion     (direccion),
        .din           (din),
        .direccion_dbg (direccion_dbg),
        .dout          (dout),
        .dout_dbg      (dout_dbg),
        .dout_valid    (dout_valid),
        .misaligned    (misaligned),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int idx);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = model_bytes[idx*4 + k];
        return v;
    endfunction

    // One falling edge in READY: predict from the byte model, then compare
    task automatic step(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] data, input logic [ADDR_W-3:0] dbg);
        int          a;
        int          nb;
        logic [31:0] v;
        logic [31:0] exp_dbg;
        logic        exp_valid;
        logic        exp_mis;
        a  = int'(addr);
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_dbg   = model_word(int'(dbg));
        exp_valid = 1'b0;
        exp_mis   = 1'b0;
        if ((rd || wr) && (a % nb != 0)) begin
            exp_mis = 1'b1;
        end else begin
            if (rd) begin
                v = 32'h0;
                for (int k = 0; k < nb; k++) v[8*k +: 8] = model_bytes[a + k];
                if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
                model_dout = v;
                exp_valid  = 1'b1;
            end
            if (wr) begin
                for (int k = 0; k < nb; k++) model_bytes[a + k] = data[8*k +: 8];
            end
        end
        read = rd; write = wr; size = sz; unsigned_ld = uns;
        direccion = addr; din = data; direccion_dbg = dbg;
        @(negedge clk);
        #2;
        chk("dout", dout, model_dout);
        chk("dout_valid", {31'b0, dout_valid}, {31'b0, exp_valid});
        chk("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
        chk("dout_dbg", dout_dbg, exp_dbg);
        chk("busy_ready", {31'b0, busy}, 32'h0);
        read = 1'b0; write = 1'b0;
    endtask

    // Reset values, then DEPTH clear edges with busy high until the last one
    task automatic clear_phase(input string tag);
        for (int i = 0; i < DEPTH * 4; i++) model_bytes[i] = INIT[8*(i%4) +: 8];
        model_dout = 32'h0;
        #1;
        chk({tag, "_rst_dout"}, dout, 32'h0);
        chk({tag, "_rst_dbg"}, dout_dbg, 32'h0);
        chk({tag, "_rst_busy"}, {31'b0, busy}, 32'h1);
        chk({tag, "_rst_flags"}, {30'b0, dout_valid, misaligned}, 32'h0);
        // requests during clear must be ignored
        read = 1'b1; write = 1'b1; size = 2'b10; direccion = '0; din = 32'hDEADBEEF;
        @(posedge clk);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            #2;
            chk({tag, "_busy"}, {31'b0, busy}, (i < DEPTH - 1) ? 32'h1 : 32'h0);
            if (i == 0) begin
                chk({tag, "_clr_dout"}, dout, 32'h0);
                chk({tag, "_clr_flags"}, {30'b0, dout_valid, misaligned}, 32'h0);
            end
        end
        read = 1'b0; write = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 2'b10, 1'b0, '0, 32'h0, (ADDR_W-2)'(i));
            chk({tag, "_sweep"}, dout_dbg, INIT);
        end
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
        direccion = '0; din = '0; direccion_dbg = '0;
        clear_phase("init");

        // word store then byte loads
        step(1'b0, 1'b1, 2'b10, 1'b0, 6'h08, 32'h80FF7F01, 4'd2);
        step(1'b1, 1'b0, 2'b00, 1'b0, 6'h08, 32'h0, 4'd2);
        chk("lb08", dout, 32'h00000001);
        step(1'b1, 1'b0, 2'b00, 1'b0, 6'h09, 32'h0, 4'd2);
        chk("lb09", dout, 32'h0000007F);
        step(1'b1, 1'b0, 2'b00, 1'b0, 6'h0A, 32'h0, 4'd2);
        chk("lb0A", dout, 32'hFFFFFFFF);
        step(1'b1, 1'b0, 2'b00, 1'b0, 6'h0B, 32'h0, 4'd2);
        chk("lb0B", dout, 32'hFFFFFF80);
        step(1'b1, 1'b0, 2'b00, 1'b1, 6'h0A, 32'h0, 4'd2);
        chk("lbu0A", dout, 32'h000000FF);
        step(1'b1, 1'b0, 2'b00, 1'b1, 6'h0B, 32'h0, 4'd2);
        chk("lbu0B", dout, 32'h00000080);

        // half store into upper lane of a zeroed word
        step(1'b0, 1'b1, 2'b10, 1'b0, 6'h0C, 32'h00000000, 4'd3);
        step(1'b0, 1'b1, 2'b01, 1'b0, 6'h0E, 32'h1234ABCD, 4'd3);
        step(1'b1, 1'b0, 2'b10, 1'b0, 6'h0C, 32'h0, 4'd3);
        chk("lw0C", dout, 32'hABCD0000);
        step(1'b1, 1'b0, 2'b01, 1'b0, 6'h0E, 32'h0, 4'd3);
        chk("lh0E", dout, 32'hFFFFABCD);
        step(1'b1, 1'b0, 2'b01, 1'b1, 6'h0E, 32'h0, 4'd3);
        chk("lhu0E", dout, 32'h0000ABCD);

        // misaligned accesses are dropped
        step(1'b1, 1'b0, 2'b10, 1'b0, 6'h05, 32'h0, 4'd1);
        chk("mis_lw", {30'b0, misaligned, dout_valid}, 32'h2);
        chk("mis_lw_dout", dout, 32'h0000ABCD);
        step(1'b0, 1'b1, 2'b01, 1'b0, 6'h03, 32'hFFFFFFFF, 4'd0);
        chk("mis_sh", {31'b0, misaligned}, 32'h1);
        step(1'b1, 1'b0, 2'b10, 1'b0, 6'h00, 32'h0, 4'd0);
        chk("mis_mem0", dout, INIT);
        chk("mis_pulse", {31'b0, misaligned}, 32'h0);

        // read-before-write on the same edge
        step(1'b0, 1'b1, 2'b10, 1'b0, 6'h10, 32'hAAAAAAAA, 4'd4);
        step(1'b1, 1'b1, 2'b10, 1'b0, 6'h10, 32'h55555555, 4'd4);
        chk("rbw_old", dout, 32'hAAAAAAAA);
        chk("rbw_dbg_old", dout_dbg, 32'hAAAAAAAA);
        step(1'b1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 4'd4);
        chk("rbw_new", dout, 32'h55555555);
        chk("rbw_dbg_new", dout_dbg, 32'h55555555);

        // randomized traffic against the byte model
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                 ADDR_W'($urandom), $urandom, (ADDR_W-2)'($urandom));
        end

        // reset in the middle of a clear restarts it from word 0
        reset = 1'b1;
        #1;
        @(posedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        clear_phase("mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
